// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding.
// Used by the buffered transmitter and intended for the future receive path.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_9600 = 5208;
    localparam int unsigned DATA_BITS         = 8;
    localparam logic        STOP_LEVEL        = 1'b1;
    localparam logic        START_LEVEL       = 1'b0;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy output.
// Pointers carry one extra MSB so a full FIFO is distinguishable from an empty one.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (level_o == (AW+1)'(DEPTH));
    assign empty_o   = (level_o == '0);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Overflowing writes and underflowing reads are ignored here, not by the caller.
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_rd) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: CPU writes bytes into a FIFO, a bit-timing FSM
// serialises them LSB first onto TXD.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic               CLK50M,
    input  logic               n_RST,
    input  logic [7:0]         WR_DATA,
    input  logic               WR_EN,
    output logic               FULL,
    output logic               EMPTY,
    output logic [FIFO_AW:0]   LEVEL,
    output logic               BUSY,
    output logic               TXD
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] CntTc = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      IdxLast = 3'(DATA_BITS - 1);

    tx_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            pop;
    logic            tc;
    logic [7:0]      fifo_rd_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i     (CLK50M),
        .rst_ni    (n_RST),
        .wr_en_i   (WR_EN),
        .wr_data_i (WR_DATA),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (FULL),
        .empty_o   (EMPTY),
        .level_o   (LEVEL)
    );

    assign tc = (cnt_q == CntTc);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (!EMPTY) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tc) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tc) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == IdxLast) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tc) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK50M or negedge n_RST) begin
        if (!n_RST) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Decoded from the async-reset state register so reset forces the line idle at once.
    always_comb begin
        TXD = STOP_LEVEL;
        unique case (state_q)
            TX_IDLE:  TXD = STOP_LEVEL;
            TX_START: TXD = START_LEVEL;
            TX_DATA:  TXD = shift_q[0];
            TX_STOP:  TXD = STOP_LEVEL;
            default:  TXD = STOP_LEVEL;
        endcase
    end

    assign BUSY = (state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: one DUT at 9600 baud timing for the single-byte frame, one at
// four clocks per bit for FIFO, back-to-back, overflow, wrap and reset scenarios.
module tb_uart_tx_buffered;

    localparam int unsigned CPB_A = 5208;
    localparam int unsigned CPB_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, wr_en_a, full_a, empty_a, busy_a, txd_a;
    logic [7:0] wr_data_a;
    logic [4:0] level_a;
    logic       rst_b_n, wr_en_b, full_b, empty_b, busy_b, txd_b;
    logic [7:0] wr_data_b;
    logic [4:0] level_b;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB_A),
        .FIFO_DEPTH   (16),
        .FIFO_AW      (4)
    ) u_dut_a (
        .CLK50M  (clk),
        .n_RST   (rst_a_n),
        .WR_DATA (wr_data_a),
        .WR_EN   (wr_en_a),
        .FULL    (full_a),
        .EMPTY   (empty_a),
        .LEVEL   (level_a),
        .BUSY    (busy_a),
        .TXD     (txd_a)
    );

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB_B),
        .FIFO_DEPTH   (16),
        .FIFO_AW      (4)
    ) u_dut_b (
        .CLK50M  (clk),
        .n_RST   (rst_b_n),
        .WR_DATA (wr_data_b),
        .WR_EN   (wr_en_b),
        .FULL    (full_b),
        .EMPTY   (empty_b),
        .LEVEL   (level_b),
        .BUSY    (busy_b),
        .TXD     (txd_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder for DUT b: samples each bit at its midpoint after the start edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge txd_b);
            #1;
            start_q.push_back(cyc);
            repeat (CPB_B + CPB_B / 2) @(posedge clk);
            #1;
            b[0] = txd_b;
            for (int i = 1; i < 8; i++) begin
                repeat (CPB_B) @(posedge clk);
                #1;
                b[i] = txd_b;
            end
            repeat (CPB_B) @(posedge clk);
            #1;
            checks++;
            if (txd_b !== 1'b1) begin
                errors++;
                $display("FAIL stop_bit got %b exp 1", txd_b);
            end
            rx_q.push_back(b);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_b(input logic [7:0] d);
        wr_data_b = d;
        wr_en_b   = 1'b1;
        tick(1);
        wr_en_b   = 1'b0;
    endtask

    task automatic test_reset;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        wr_data_a = 8'h00; wr_data_b = 8'h00;
        tick(3);
        checks++;
        if ({txd_a, busy_a, full_a, empty_a, level_a} !== {4'b1001, 5'd0}) begin
            errors++;
            $display("FAIL reset_a got %b exp %b",
                     {txd_a, busy_a, full_a, empty_a, level_a}, {4'b1001, 5'd0});
        end
        checks++;
        if ({txd_b, busy_b, full_b, empty_b, level_b} !== {4'b1001, 5'd0}) begin
            errors++;
            $display("FAIL reset_b got %b exp %b",
                     {txd_b, busy_b, full_b, empty_b, level_b}, {4'b1001, 5'd0});
        end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_byte;
        logic [9:0] exp_frame;
        exp_frame = {1'b1, 8'h41, 1'b0};
        tick(1000);
        wr_data_a = 8'h41;
        wr_en_a   = 1'b1;
        tick(1);
        wr_en_a   = 1'b0;
        checks++;
        if ({empty_a, level_a, txd_a, busy_a} !== {1'b0, 5'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_after_write got %b exp %b",
                     {empty_a, level_a, txd_a, busy_a}, {1'b0, 5'd1, 1'b1, 1'b0});
        end
        tick(1);
        checks++;
        if ({txd_a, busy_a, level_a, empty_a} !== {1'b0, 1'b1, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_after_pop got %b exp %b",
                     {txd_a, busy_a, level_a, empty_a}, {1'b0, 1'b1, 5'd0, 1'b1});
        end
        tick(CPB_A / 2);
        for (int j = 0; j < 10; j++) begin
            if (j > 0) tick(CPB_A);
            checks++;
            if (txd_a !== exp_frame[j]) begin
                errors++;
                $display("FAIL single_bit%0d got %b exp %b", j, txd_a, exp_frame[j]);
            end
        end
        tick(CPB_A / 2 - 1);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_last got %b exp 1", busy_a);
        end
        tick(1);
        checks++;
        if ({busy_a, txd_a, empty_a} !== 3'b011) begin
            errors++;
            $display("FAIL single_busy_end got %b exp 011", {busy_a, txd_a, empty_a});
        end
    endtask

    task automatic test_back_to_back;
        rx_q.delete(); start_q.delete();
        write_b(8'h55);
        write_b(8'hAA);
        for (int i = 0; i < 300 && rx_q.size() < 2; i++) tick(1);
        tick(4);
        checks++;
        if (rx_q.size() != 2 || start_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 2", rx_q.size());
        end else begin
            checks++;
            if ({rx_q[0], rx_q[1]} !== 16'h55AA) begin
                errors++;
                $display("FAIL b2b_data got %h exp 55aa", {rx_q[0], rx_q[1]});
            end
            checks++;
            if (start_q[1] - start_q[0] != 10 * CPB_B + 1) begin
                errors++;
                $display("FAIL b2b_gap got %0d exp %0d", start_q[1] - start_q[0], 10 * CPB_B + 1);
            end
        end
    endtask

    task automatic test_simultaneous;
        rx_q.delete(); start_q.delete();
        write_b(8'h31);
        checks++;
        if ({level_b, busy_b} !== {5'd1, 1'b0}) begin
            errors++;
            $display("FAIL simul_pre got %b exp %b", {level_b, busy_b}, {5'd1, 1'b0});
        end
        write_b(8'h32);
        checks++;
        if ({level_b, busy_b} !== {5'd1, 1'b1}) begin
            errors++;
            $display("FAIL simul_post got %b exp %b", {level_b, busy_b}, {5'd1, 1'b1});
        end
        for (int i = 0; i < 300 && rx_q.size() < 2; i++) tick(1);
        tick(4);
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h31 || rx_q[1] !== 8'h32) begin
            errors++;
            $display("FAIL simul_order got %0d bytes exp 31 32", rx_q.size());
        end
    endtask

    task automatic test_overflow;
        rx_q.delete(); start_q.delete();
        for (int i = 0; i < 18; i++) begin
            wr_data_b = 8'(i);
            wr_en_b   = 1'b1;
            tick(1);
            if (i == 15) begin
                checks++;
                if ({full_b, level_b} !== {1'b0, 5'd15}) begin
                    errors++;
                    $display("FAIL ovf_pre_full got %b exp %b", {full_b, level_b}, {1'b0, 5'd15});
                end
            end
            if (i == 16) begin
                checks++;
                if ({full_b, level_b} !== {1'b1, 5'd16}) begin
                    errors++;
                    $display("FAIL ovf_full got %b exp %b", {full_b, level_b}, {1'b1, 5'd16});
                end
            end
        end
        wr_en_b = 1'b0;
        checks++;
        if ({full_b, level_b} !== {1'b1, 5'd16}) begin
            errors++;
            $display("FAIL ovf_drop got %b exp %b", {full_b, level_b}, {1'b1, 5'd16});
        end
        for (int i = 0; i < 1000 && rx_q.size() < 17; i++) tick(1);
        tick(60);
        checks++;
        if (rx_q.size() != 17) begin
            errors++;
            $display("FAIL ovf_count got %0d exp 17", rx_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (rx_q[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL ovf_byte%0d got %h exp %h", i, rx_q[i], 8'(i));
                end
            end
        end
    endtask

    task automatic test_wrap;
        int   sent;
        logic full_seen;
        rx_q.delete(); start_q.delete();
        sent = 0;
        full_seen = 1'b0;
        for (int i = 0; i < 4000 && sent < 40; i++) begin
            if (level_b < 5'd8) begin
                write_b(8'h80 + 8'(sent));
                sent++;
            end else begin
                tick(1);
            end
            full_seen = full_seen | full_b;
        end
        for (int i = 0; i < 1000 && rx_q.size() < 40; i++) begin
            tick(1);
            full_seen = full_seen | full_b;
        end
        tick(4);
        checks++;
        if (full_seen !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full got %b exp 0", full_seen);
        end
        checks++;
        if (rx_q.size() != 40) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 40", rx_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (rx_q[i] !== 8'h80 + 8'(i)) begin
                    errors++;
                    $display("FAIL wrap_byte%0d got %h exp %h", i, rx_q[i], 8'h80 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        rx_q.delete(); start_q.delete();
        write_b(8'hF0);
        write_b(8'h33);
        tick(17);
        checks++;
        if ({txd_b, busy_b, level_b} !== {1'b0, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL midrst_pre got %b exp %b", {txd_b, busy_b, level_b}, {1'b0, 1'b1, 5'd1});
        end
        #2;
        rst_b_n = 1'b0;
        #1;
        checks++;
        if ({txd_b, busy_b, full_b, empty_b, level_b} !== {4'b1001, 5'd0}) begin
            errors++;
            $display("FAIL midrst_async got %b exp %b",
                     {txd_b, busy_b, full_b, empty_b, level_b}, {4'b1001, 5'd0});
        end
        tick(60);
        rst_b_n = 1'b1;
        tick(2);
        rx_q.delete(); start_q.delete();
        write_b(8'h0F);
        for (int i = 0; i < 200 && rx_q.size() < 1; i++) tick(1);
        tick(4);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h0F) begin
            errors++;
            $display("FAIL midrst_after got %0d bytes exp one 0f", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_simultaneous();
        test_overflow();
        test_wrap();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
